quad_velocity_meter: RTL and testbench
======================================

// Module: quad_velocity_meter
// PURPOSE
//  Upstream of the PID/PWM velocity loop: converts raw encoder channels A/B into a wrapping
//  13-bit position and a per-gate velocity (edges per gate window, 4x decode). Produces one
//  o_vel_valid pulse per window; the controller latches o_velocity as its process value on it.
//  Replaces ad-hoc velocity derivation; single clock domain, no external debouncer required.
// PARAMETERS
//  GATE_CYCLES  500000  clocks per velocity window (10 ms @ 50 MHz); must be >= 4
//  POS_W        13      position counter width, wraps modulo 2**POS_W
//  VEL_W        16      velocity magnitude width, unsigned, saturating
//  SYNC_STAGES  2       flip-flop synchroniser depth on i_A/i_B (>= 2)
// PORTS
//  i_clk        in   1      system clock
//  i_rst_n      in   1      synchronous reset, active-low
//  i_A          in   1      encoder channel A, asynchronous
//  i_B          in   1      encoder channel B, asynchronous
//  i_clr_pos    in   1      synchronous clear of o_position only
//  o_position   out  POS_W  signed-agnostic wrapping edge count (CW = +1)
//  o_velocity   out  VEL_W  |net edges| in last completed window, saturated
//  o_direction  out  1      1 = net CW in last window, 0 = CCW or zero
//  o_vel_valid  out  1      one-cycle pulse when o_velocity/o_direction update
//  o_err        out  1      sticky: illegal transition (A and B changed same sample)
// BEHAVIOUR
//  - Reset (i_rst_n=0 at clock edge): all outputs 0, sync chain, prev state, gate timer,
//    window accumulator cleared; prev AB state loaded from sync output on first cycle after.
//  - Sync: i_A/i_B pass SYNC_STAGES FFs; decode latency = SYNC_STAGES+1 clocks to o_position.
//  - Decode, {A,B} prev->cur: 00->10->11->01->00 = +1 (CW); reverse = -1; no change = 0;
//    both bits change = illegal: no count, o_err set, held until reset.
//  - o_position: +/-1 per legal edge, wraps 2**POS_W-1 <-> 0 without flag.
//    i_clr_pos with a same-cycle edge: clear wins, edge discarded.
//  - Gate timer counts 0..GATE_CYCLES-1 free-running. Signed accumulator (VEL_W+1 bits,
//    saturating at +/-(2**VEL_W-1)) sums edges. Edge on terminal cycle belongs to closing window.
//  - Terminal cycle: register |acc| -> o_velocity, (acc>0) -> o_direction, accumulator
//    restarts at 0 (plus no carry); o_vel_valid high next cycle for exactly one clock.
//  - Outputs o_velocity/o_direction stable between valid pulses; no backpressure.
//  - Reset mid-window discards partial window; first valid GATE_CYCLES+1 clocks after release.
// CONFIGURATION
//  QUAD_VEL_FILTER_EN defined: o_velocity/o_direction = 4-window moving average of signed
//    window counts (sum>>>2, truncated toward -inf, then magnitude/sign); history regs reset
//    to 0, so first 3 windows are under-reported; o_vel_valid delayed one extra clock.
//  Undefined: raw last-window value as above; no history registers synthesised.
// STRUCTURE
//  quad_pkg: QUAD_CW/QUAD_CCW/QUAD_IDLE/QUAD_ILLEGAL step encodings, 16-entry
//    {prev,cur}->step decode table function, default GATE_CYCLES constant.
//  Sub-module quad_sync_decode: synchroniser + prev-state reg + table lookup -> step code;
//    top holds position counter, gate timer, accumulator, output regs, optional filter.
// TESTING (sim with GATE_CYCLES=100, SYNC_STAGES=2)
//  1 Reset held 5 clocks, A=B=0 -> all outputs 0; first o_vel_valid at clock 101 after release.
//  2 CW sequence 00,10,11,01 x5 (20 edges, 4 clocks apart) within one window ->
//    o_position=20, o_velocity=20, o_direction=1, one valid pulse.
//  3 Position at 8191 plus one CW edge -> 0; then one CCW edge -> 8191; o_err stays 0.
//  4 AB 00->11 in one sample -> o_err=1, o_position unchanged; persists until i_rst_n=0.
//  5 i_clr_pos asserted same cycle as decoded edge, position 37 -> o_position=0 next clock.
//  6 FILTER_EN: windows of +8,+8,+8,+8 CW edges -> o_velocity 2,4,6,8; valid 1 clock later than raw.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature velocity meter: step encodings,
// the {prev,cur} -> step decode table and the default gate length.
package quad_pkg;

  // One decoded encoder step per clock.
  typedef enum logic [1:0] {
    QUAD_IDLE    = 2'b00,
    QUAD_CW      = 2'b01,
    QUAD_CCW     = 2'b10,
    QUAD_ILLEGAL = 2'b11
  } quad_step_e;

  // 10 ms window at 50 MHz.
  localparam int QUAD_GATE_CYCLES_DEFAULT = 500000;

  // 16-entry table indexed by {prev A, prev B, cur A, cur B}.
  // CW order is 00 -> 10 -> 11 -> 01 -> 00; both bits moving is illegal.
  function automatic quad_step_e quad_decode(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab);
    quad_step_e step;
    case ({prev_ab, cur_ab})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step = QUAD_CW;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step = QUAD_CCW;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: step = QUAD_ILLEGAL;
      default:                            step = QUAD_IDLE;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_sync_decode.sv
// Synchronises the asynchronous encoder channels and turns each sampled
// {A,B} change into a single step code. The step is combinational from the
// last synchroniser stage so the position register sits one clock behind it.
module quad_sync_decode
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  output quad_step_e step
);

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [1:0]             cur_ab;
  logic [1:0]             prev_ab;
  logic                   prev_valid;

  assign cur_ab = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // Multi-stage synchroniser on both channels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b};
    end
  end

  // Previous sampled state; the first cycle after reset only loads it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_ab    <= 2'b00;
      prev_valid <= 1'b0;
    end else begin
      prev_ab    <= cur_ab;
      prev_valid <= 1'b1;
    end
  end

  // Table lookup, suppressed until prev_ab holds a real sample.
  always_comb begin
    step = QUAD_IDLE;
    if (prev_valid) step = quad_decode(prev_ab, cur_ab);
  end

endmodule

// File: rtl/quad_velocity_meter.sv
// Quadrature encoder position counter and gated velocity meter (4x decode).
// Optional feature macro: QUAD_VEL_FILTER_EN -- when defined, the reported
// velocity is a 4-window moving average and o_vel_valid comes one clock later.
module quad_velocity_meter
  import quad_pkg::*;
#(
  parameter int GATE_CYCLES = QUAD_GATE_CYCLES_DEFAULT,
  parameter int POS_W       = 13,
  parameter int VEL_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_A,
  input  logic             i_B,
  input  logic             i_clr_pos,
  output logic [POS_W-1:0] o_position,
  output logic [VEL_W-1:0] o_velocity,
  output logic             o_direction,
  output logic             o_vel_valid,
  output logic             o_err
);

  localparam int TMR_W = $clog2(GATE_CYCLES);
  localparam logic signed [VEL_W:0] ACC_MAX = {1'b0, {VEL_W{1'b1}}};
  localparam logic signed [VEL_W:0] ACC_MIN = -ACC_MAX;

  quad_step_e             step;
  logic [TMR_W-1:0]       timer;
  logic                   terminal;
  logic signed [VEL_W:0]  acc;
  logic signed [VEL_W:0]  acc_next;

  // Magnitude of a saturated signed count; always fits in VEL_W bits.
  function automatic logic [VEL_W-1:0] mag(input logic signed [VEL_W:0] v);
    return VEL_W'(v[VEL_W] ? -v : v);
  endfunction

  quad_sync_decode #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_decode (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .a    (i_A),
    .b    (i_B),
    .step (step)
  );

  assign terminal = (timer == TMR_W'(GATE_CYCLES - 1));

  // Wrapping position counter; a clear beats a same-cycle edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr_pos) begin
      o_position <= '0;
    end else begin
      case (step)
        QUAD_CW:  o_position <= o_position + 1'b1;
        QUAD_CCW: o_position <= o_position - 1'b1;
        default:  o_position <= o_position;
      endcase
    end
  end

  // Sticky illegal-transition flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                   o_err <= 1'b0;
    else if (step == QUAD_ILLEGAL)  o_err <= 1'b1;
  end

  // Saturating window sum including this cycle's step.
  always_comb begin
    acc_next = acc;
    case (step)
      QUAD_CW:  if (acc != ACC_MAX) acc_next = acc + (VEL_W+1)'(1);
      QUAD_CCW: if (acc != ACC_MIN) acc_next = acc - (VEL_W+1)'(1);
      default:  acc_next = acc;
    endcase
  end

  // Free-running gate timer and accumulator; both restart on the terminal cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || terminal) begin
      timer <= '0;
      acc   <= '0;
    end else begin
      timer <= timer + 1'b1;
      acc   <= acc_next;
    end
  end

`ifdef QUAD_VEL_FILTER_EN
  logic signed [VEL_W:0]   win_reg;
  logic                    win_ready;
  logic signed [VEL_W:0]   hist [3];
  logic signed [VEL_W+2:0] sum;
  logic signed [VEL_W:0]   avg;

  function automatic logic signed [VEL_W+2:0] sext(input logic signed [VEL_W:0] v);
    return {{2{v[VEL_W]}}, v};
  endfunction

  // Current window plus three previous ones, floor-divided by four.
  always_comb begin
    sum = sext(win_reg) + sext(hist[0]) + sext(hist[1]) + sext(hist[2]);
    avg = (VEL_W+1)'(sum >>> 2);
  end

  // Capture the closed window, then average it in the following cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      win_reg     <= '0;
      win_ready   <= 1'b0;
      hist[0]     <= '0;
      hist[1]     <= '0;
      hist[2]     <= '0;
      o_velocity  <= '0;
      o_direction <= 1'b0;
      o_vel_valid <= 1'b0;
    end else begin
      win_ready   <= terminal;
      o_vel_valid <= win_ready;
      if (terminal) win_reg <= acc_next;
      if (win_ready) begin
        hist[0]     <= win_reg;
        hist[1]     <= hist[0];
        hist[2]     <= hist[1];
        o_velocity  <= mag(avg);
        o_direction <= (avg > 0);
      end
    end
  end
`else
  // Register the closed window directly; valid is visible alongside it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_velocity  <= '0;
      o_direction <= 1'b0;
      o_vel_valid <= 1'b0;
    end else begin
      o_vel_valid <= terminal;
      if (terminal) begin
        o_velocity  <= mag(acc_next);
        o_direction <= (acc_next > 0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_quad_velocity_meter.sv
// Directed bench for quad_velocity_meter (GATE_CYCLES=100, SYNC_STAGES=2).
// Expected window results are pushed when the stimulus for a window is
// driven and popped by a monitor on each o_vel_valid pulse.
module tb_quad_velocity_meter;

  localparam int GATE = 100;
`ifdef QUAD_VEL_FILTER_EN
  localparam int PHASE = 1;
`else
  localparam int PHASE = 0;
`endif

  typedef struct {
    int vel;
    int dir;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        clr_pos = 1'b0;
  logic [12:0] position;
  logic [15:0] velocity;
  logic        direction;
  logic        vel_valid;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [1:0]  ab = 2'b00;
  int          hist [3];
  exp_t        sb [$];
  exp_t        mon_e;

  quad_velocity_meter #(
    .GATE_CYCLES(GATE),
    .POS_W      (13),
    .VEL_W      (16),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_A        (a),
    .i_B        (b),
    .i_clr_pos  (clr_pos),
    .o_position (position),
    .o_velocity (velocity),
    .o_direction(direction),
    .o_vel_valid(vel_valid),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; matches the gate window boundaries.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected report for a window with net signed edge count w.
  task automatic push_window(input int w);
    exp_t e;
    int   s;
`ifdef QUAD_VEL_FILTER_EN
    s = w + hist[0] + hist[1] + hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = w;
    s = s >>> 2;
`else
    s = w;
`endif
    e.vel = (s < 0) ? -s : s;
    e.dir = (s > 0) ? 1 : 0;
    sb.push_back(e);
    $display("push window=%0d expect vel=%0d dir=%0d", w, e.vel, e.dir);
  endtask

  task automatic wait_until(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) check("wait_timeout", cyc, n);
  endtask

  task automatic drive_ab();
    a = ab[1];
    b = ab[0];
  endtask

  task automatic cw(input int gap);
    case (ab)
      2'b00:   ab = 2'b10;
      2'b10:   ab = 2'b11;
      2'b11:   ab = 2'b01;
      default: ab = 2'b00;
    endcase
    drive_ab();
    repeat (gap) @(negedge clk);
  endtask

  task automatic ccw(input int gap);
    case (ab)
      2'b00:   ab = 2'b01;
      2'b01:   ab = 2'b11;
      2'b11:   ab = 2'b10;
      default: ab = 2'b00;
    endcase
    drive_ab();
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    clr_pos = 1'b0;
    ab      = 2'b00;
    drive_ab();
    hist    = '{0, 0, 0};
    repeat (5) @(negedge clk);
    check("rst_position", position, 0);
    check("rst_velocity", velocity, 0);
    check("rst_direction", direction, 0);
    check("rst_valid", vel_valid, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
  endtask

  // Scoreboard side: each valid pulse consumes one expected window.
  always @(negedge clk) begin
    if (rst_n && vel_valid) begin
      // Cycle 1 is the one in which reset releases, so the raw pulse lands in
      // cycle GATE+1, i.e. after edge GATE.
      check("valid_phase", cyc % GATE, PHASE);
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        $display("valid cyc=%0d vel=%0d dir=%0d exp_vel=%0d exp_dir=%0d",
                 cyc, velocity, direction, mon_e.vel, mon_e.dir);
        check("velocity", velocity, mon_e.vel);
        check("direction", direction, mon_e.dir);
      end
    end
  end

  initial begin
    do_reset();

    // Window 1: 20 CW edges, 4 clocks apart.
    push_window(20);
    wait_until(2);
    repeat (20) cw(4);
    wait_until(90);
    check("pos_after_20cw", position, 20);
    check("err_after_cw", err, 0);

    // Window 2: 21 CCW edges take the count from 20 down through 0 to 8191.
    push_window(-21);
    wait_until(102);
    repeat (21) ccw(4);
    wait_until(190);
    check("pos_wrap_down", position, 8191);

    // Window 3: 8191 + CW -> 0, then CCW -> 8191.
    push_window(0);
    wait_until(202);
    cw(4);
    wait_until(210);
    check("pos_wrap_up", position, 0);
    wait_until(212);
    ccw(4);
    wait_until(220);
    check("pos_wrap_back", position, 8191);
    check("err_after_wrap", err, 0);

    // Window 4: plain clear, then climb to 37.
    push_window(37);
    wait_until(302);
    clr_pos = 1'b1;
    @(negedge clk);
    clr_pos = 1'b0;
    check("pos_clear", position, 0);
    wait_until(304);
    repeat (37) cw(2);
    wait_until(385);
    check("pos_37", position, 37);

    // Window 5: clear on the same cycle the edge is decoded; clear wins.
    push_window(1);
    wait_until(402);
    cw(0);
    wait_until(404);
    clr_pos = 1'b1;
    @(negedge clk);
    clr_pos = 1'b0;
    check("pos_clr_vs_edge", position, 0);
    wait_until(410);
    check("pos_clr_hold", position, 0);

    // Window 6: both channels flip in one sample.
    push_window(0);
    wait_until(502);
    ab = ab ^ 2'b11;
    drive_ab();
    wait_until(510);
    check("err_set", err, 1);
    check("pos_illegal", position, 0);
    wait_until(620);
    check("err_sticky", err, 1);

    // Reset mid-window 7 discards it and clears the error.
    do_reset();

    // Four windows of +8 CW edges each.
    for (int k = 0; k < 4; k++) begin
      push_window(8);
      wait_until(100 * k + 2);
      repeat (8) cw(4);
    end
    wait_until(410);
    check("sb_drained", sb.size(), 0);
    check("pos_final", position, 32);
    check("err_final", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
